// File: rtl/call_if.sv
// Bundle of the call-light controller's push-button inputs and status outputs.
//   call, cancel             : level-sensitive button requests (master -> slave)
//   light_state              : indicator state, 1 = on          (slave -> master)
//   call_count, on_cycles    : saturating activity counters      (slave -> master)
interface call_if #(
    parameter int CNT_W = 16
);
    logic             call;
    logic             cancel;
    logic             light_state;
    logic [CNT_W-1:0] call_count;
    logic [CNT_W-1:0] on_cycles;

    modport master (
        output call, cancel,
        input  light_state, call_count, on_cycles
    );

    modport slave (
        input  call, cancel,
        output light_state, call_count, on_cycles
    );
endinterface

// File: rtl/call_system.sv
// Cabin attendant call-light controller. A call press lights the indicator,
// a cancel press extinguishes it; call wins when both are pressed. Optional
// synchroniser stages on the inputs and two saturating activity counters.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : call_if slave (call/cancel in, light_state/call_count/on_cycles out)
// The CNT_W of this module must match the CNT_W of the connected interface.
module call_system #(
    parameter int SYNC_STAGES = 0,
    parameter int CNT_W       = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    call_if.slave  bus
);
    typedef enum logic {OFF = 1'b0, ON = 1'b1} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic call_s;
    logic cancel_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign call_s   = bus.call;
            assign cancel_s = bus.cancel;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] call_q;
            logic [SYNC_STAGES-1:0] cancel_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    call_q   <= '0;
                    cancel_q <= '0;
                end else begin
                    call_q[0]   <= bus.call;
                    cancel_q[0] <= bus.cancel;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        call_q[i]   <= call_q[i-1];
                        cancel_q[i] <= cancel_q[i-1];
                    end
                end
            end

            assign call_s   = call_q[SYNC_STAGES-1];
            assign cancel_s = cancel_q[SYNC_STAGES-1];
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] call_count_q, call_count_d;
    logic [CNT_W-1:0] on_cycles_q, on_cycles_d;

    // Call has priority: a simultaneous press turns the light on.
    always_comb begin
        state_d = (call_s || (state_q == ON && !cancel_s)) ? ON : OFF;

        call_count_d = call_count_q;
        if (state_q == OFF && state_d == ON && call_count_q != CNT_MAX)
            call_count_d = call_count_q + 1'b1;

        // Counts edges at which the registered light is already on.
        on_cycles_d = on_cycles_q;
        if (state_q == ON && on_cycles_q != CNT_MAX)
            on_cycles_d = on_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= OFF;
            call_count_q <= '0;
            on_cycles_q  <= '0;
        end else begin
            state_q      <= state_d;
            call_count_q <= call_count_d;
            on_cycles_q  <= on_cycles_d;
        end
    end

    assign bus.light_state = (state_q == ON);
    assign bus.call_count  = call_count_q;
    assign bus.on_cycles   = on_cycles_q;
endmodule

// File: tb/tb_call_system.sv
module tb_call_system;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    call_if #(.CNT_W(16)) a_if ();
    call_if #(.CNT_W(2))  b_if ();

    call_system #(.SYNC_STAGES(0), .CNT_W(16)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    call_system #(.SYNC_STAGES(2), .CNT_W(2)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic l, input int cc, input int oc);
        chk({tag, ".light"}, a_if.light_state, l);
        chk({tag, ".cnt"},   a_if.call_count, cc);
        chk({tag, ".on"},    a_if.on_cycles, oc);
    endtask

    // One call pulse then one cancel pulse on the synchronised instance;
    // each takes three edges to reach the light.
    task automatic b_cycle(input int exp_cnt);
        b_if.call = 1'b1;
        step();
        b_if.call = 1'b0;
        step();
        step();
        chk("b_cyc_on", b_if.light_state, 1'b1);
        chk("b_cyc_cnt", b_if.call_count, exp_cnt);
        b_if.cancel = 1'b1;
        step();
        b_if.cancel = 1'b0;
        step();
        step();
        chk("b_cyc_off", b_if.light_state, 1'b0);
    endtask

    initial begin
        a_if.call = 1'b0; a_if.cancel = 1'b0;
        b_if.call = 1'b0; b_if.cancel = 1'b0;

        // Reset, then idle
        step();
        step();
        chk_a("rst", 1'b0, 0, 0);
        chk("rst_b.light", b_if.light_state, 1'b0);
        chk("rst_b.cnt",   b_if.call_count, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("idle", 1'b0, 0, 0);
        end

        // Cancel while off, then call, then cancel
        a_if.cancel = 1'b1;
        step(); chk_a("cxl_off1", 1'b0, 0, 0);
        step(); chk_a("cxl_off2", 1'b0, 0, 0);
        a_if.cancel = 1'b0; a_if.call = 1'b1;
        step(); chk_a("call1", 1'b1, 1, 0);
        step(); chk_a("call2", 1'b1, 1, 1);
        a_if.call = 1'b0; a_if.cancel = 1'b1;
        step(); chk_a("cancel", 1'b0, 1, 2);
        a_if.cancel = 1'b0;

        // Simultaneous press: call wins, counted once
        a_if.call = 1'b1; a_if.cancel = 1'b1;
        step(); chk_a("both1", 1'b1, 2, 2);
        step(); chk_a("both2", 1'b1, 2, 3);
        step(); chk_a("both3", 1'b1, 2, 4);
        a_if.call = 1'b0; a_if.cancel = 1'b0;

        // Hold for five cycles, then a one-cycle cancel
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_a("hold", 1'b1, 2, 4 + i);
        end
        a_if.cancel = 1'b1;
        step(); chk_a("cxl_pulse", 1'b0, 2, 10);
        a_if.cancel = 1'b0;
        step(); chk_a("off_hold", 1'b0, 2, 10);

        // Asynchronous reset while on
        a_if.call = 1'b1;
        step(); chk_a("reon", 1'b1, 3, 10);
        a_if.call = 1'b0;
        step(); chk_a("reon2", 1'b1, 3, 11);
        #2 rst_n = 1'b0;
        #1 chk_a("async_rst", 1'b0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); chk_a("post_rst", 1'b0, 0, 0);

        // Synchronised instance: latency and saturation
        b_if.call = 1'b1;
        step(); chk("b_lat1", b_if.light_state, 1'b0);
        b_if.call = 1'b0;
        step(); chk("b_lat2", b_if.light_state, 1'b0);
        step(); chk("b_lat3", b_if.light_state, 1'b1);
        chk("b_cnt1", b_if.call_count, 1);
        chk("b_on0",  b_if.on_cycles, 0);
        b_if.cancel = 1'b1;
        step(); chk("b_cx1", b_if.light_state, 1'b1);
        b_if.cancel = 1'b0;
        step(); chk("b_cx2", b_if.light_state, 1'b1);
        step(); chk("b_cx3", b_if.light_state, 1'b0);
        chk("b_on_sat", b_if.on_cycles, 3);
        b_cycle(2);
        b_cycle(3);
        b_cycle(3);
        chk("b_cnt_sat", b_if.call_count, 3);
        chk("b_on_sat2", b_if.on_cycles, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/call_system.md
Name: call_system

Overview:
- Cabin attendant call-light controller: a passenger `call` button lights an indicator and a `cancel` button extinguishes it.
- The light is a single registered state bit; `call` has priority over `cancel`.
- Optional input synchronisers and activity counters support status reporting.
- Sits between debounced push-button inputs and the indicator driver / status bus.

Parameters:
- SYNC_STAGES, 0, number of flip-flop synchroniser stages on `call` and `cancel`. 0 means inputs are sampled directly; legal range 0..3.
- CNT_W, 16, width of the activity counters.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
- call  input  1  call request, level-sensitive, active-high.
- cancel  input  1  cancel request, level-sensitive, active-high.
- light_state  output  1  indicator state; 1 = light on.
- call_count  output  CNT_W  number of off->on transitions of `light_state` since reset, saturating.
- on_cycles  output  CNT_W  number of clock cycles `light_state` has been 1 since reset, saturating.

Behaviour:
- Reset:
  - rst_n low clears `light_state`, `call_count`, `on_cycles` and all synchroniser flops to 0 immediately, without waiting for a clock edge.
  - Release of rst_n is sampled on the next rising edge.
- Input path:
  - `call_s` and `cancel_s` are `call` and `cancel` delayed through SYNC_STAGES flops.
  - With SYNC_STAGES=0 they are the raw inputs.
- State machine: two states, OFF (light_state=0) and ON (light_state=1). Updated only on the rising clk edge:
  - call_s=1 -> next state ON, whatever the value of cancel_s (call wins on simultaneous press).
  - call_s=0, cancel_s=1 -> next state OFF.
  - call_s=0, cancel_s=0 -> hold current state.
- Equivalent next-state equation: light_next = call_s | (light_state & ~cancel_s).
- Latency:
  - `light_state` reflects inputs sampled at an edge immediately after that edge: 1 clock cycle when SYNC_STAGES=0, SYNC_STAGES+1 cycles otherwise.
  - No combinational path from inputs to outputs.
- Holding `call` high keeps the light on continuously. `cancel` while OFF has no effect.
- call_count:
  - Increments on every edge where the state goes OFF->ON.
  - ON->ON does not count.
  - Saturates at 2^CNT_W-1.
- on_cycles:
  - Increments on every edge where the registered light_state is 1.
  - Saturates at 2^CNT_W-1; no wrap-around.
- Unknown/X inputs are not required to be handled. Inputs are assumed valid from the first post-reset edge.
- Reset asserted mid-operation: light turns off at once, and both counters clear at once.

Test Plan:
- Reset then idle: rst_n=0 for 20 ns, then 1 with call=0, cancel=0 -> light_state=0, call_count=0, on_cycles=0 for all following cycles.
- Call then cancel (10 ns clock, SYNC_STAGES=0): cancel=1 for 20 ns, then call=1 for 20 ns, then cancel=1 -> light stays 0, goes 1 at the first edge with call=1, returns to 0 at the first edge with cancel=1; call_count=1.
- Simultaneous press: call=1, cancel=1 with light OFF -> light_state=1 after the next edge and stays 1 while both are held; call_count increments by exactly 1.
- Hold behaviour: light ON, then call=0, cancel=0 for 5 cycles -> light_state stays 1 and on_cycles increases by 5. A later cancel=1 pulse of one cycle -> light_state=0 on that edge.
- Asynchronous reset mid-ON: assert rst_n=0 between clock edges while the light is ON -> light_state, call_count and on_cycles go to 0 before the next edge.
- SYNC_STAGES=2 with CNT_W=2:
  - A call pulse shows up on light_state 3 edges after it is sampled.
  - Four separate call/cancel cycles -> call_count saturates at 3.
